noc_traffic_gen: RTL and testbench

NOC_TRAFFIC_GEN -- requirements
Module: noc_traffic_gen

---
 rtl/noc_pkg.sv | 36 +++
 rtl/noc_flit_pack.sv | 32 +++
 rtl/noc_traffic_gen.sv | 251 +++++++++++++++++++++++++
 tb/tb_noc_traffic_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: flit type/marker codes, field widths,
// generator modes, FSM state encoding and the pad-width helper.
package noc_pkg;

    localparam int CODE_W = 4;
    localparam int TYPE_W = 3;
    localparam int LEN_W  = 8;

    localparam logic [CODE_W-1:0] HEAD_CODE = 4'h5;
    localparam logic [CODE_W-1:0] HEAD_END  = 4'hA;
    localparam logic [CODE_W-1:0] TAIL_CODE = 4'h0;
    localparam logic [CODE_W-1:0] TAIL_END  = 4'hF;

    localparam logic [TYPE_W-1:0] TYPE_WRITE  = 3'b100;
    localparam logic [TYPE_W-1:0] TYPE_RD_REQ = 3'b010;

    localparam logic [1:0] MODE_WR    = 2'd0;
    localparam logic [1:0] MODE_RD    = 2'd1;
    localparam logic [1:0] MODE_WR_RD = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY,
        ST_TAIL,
        ST_GAP,
        ST_DONE
    } gen_state_t;

    // Zero padding left over below the packed head/tail fields.
    function automatic int pad_width(input int dw, input int idw, input int vc, input int aw);
        return dw - 2 * CODE_W - 2 * idw - TYPE_W - LEN_W - vc - aw;
    endfunction

endpackage

// File: rtl/noc_flit_pack.sv
// Combinational head/tail flit packer shared by the traffic generator and NSU.
// Fields are packed MSB-first with zero padding in the low bits.
module noc_flit_pack
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH     = 128,
    parameter int ID_WIDTH       = 4,
    parameter int VIRTUAL_CH_NUM = 16,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                      is_tail,
    input  logic [ID_WIDTH-1:0]       src,
    input  logic [ID_WIDTH-1:0]       dst,
    input  logic [TYPE_W-1:0]         ptype,
    input  logic [VIRTUAL_CH_NUM-1:0] vc_field,
    input  logic [LEN_W-1:0]          axi_len,
    input  logic [AXI_ADDR_WIDTH-1:0] word,
    output logic [DATA_WIDTH-1:0]     flit
);

    localparam int PAD_W   = pad_width(DATA_WIDTH, ID_WIDTH, VIRTUAL_CH_NUM, AXI_ADDR_WIDTH);
    localparam int FIELD_W = DATA_WIDTH - PAD_W;

    logic [FIELD_W-1:0] fields;

    always_comb begin
        fields = {is_tail ? TAIL_CODE : HEAD_CODE, src, dst, ptype, vc_field,
                  axi_len, word, is_tail ? TAIL_END : HEAD_END};
        flit   = DATA_WIDTH'(fields) << PAD_W;
    end

endmodule

// File: rtl/noc_traffic_gen.sv
// NoC traffic generator: emits write and/or read-request packets
// (head, body..., tail) with programmable count, address stride and gap.
module noc_traffic_gen
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH     = 128,
    parameter int ID_WIDTH       = 4,
    parameter int VIRTUAL_CH_NUM = 16,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int FLIT_NUM_MAX   = 16
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst_n,
    input  logic                      start,
    input  logic [1:0]                cfg_mode,
    input  logic [15:0]               cfg_pkt_num,
    input  logic [7:0]                cfg_len,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_stride,
    input  logic [7:0]                cfg_gap,
    input  logic [2*ID_WIDTH-1:0]     cfg_ids,
    input  logic                      nsu_busy,
    output logic [DATA_WIDTH:0]       noc2axi_data,
    output logic                      s_is_head,
    output logic                      s_is_tail,
    output logic                      gen_busy,
    output logic                      gen_done
);

    localparam int BODY_W    = (FLIT_NUM_MAX > 1) ? $clog2(FLIT_NUM_MAX) : 1;
    localparam int IDX_PAD_W = AXI_ADDR_WIDTH - LEN_W;

    gen_state_t                state;
    logic [1:0]                mode_q;
    logic [15:0]               pkt_num_q;
    logic [7:0]                len_q;
    logic [AXI_ADDR_WIDTH-1:0] stride_q;
    logic [7:0]                gap_q;
    logic [2*ID_WIDTH-1:0]     ids_q;

    logic [15:0]               cur_idx;
    logic                      cur_rd;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr;
    logic [VIRTUAL_CH_NUM-1:0] cur_order;
    logic [BODY_W-1:0]         body_left;
    logic [7:0]                gap_cnt;
    logic [DATA_WIDTH-1:0]     data_cnt;

    logic [DATA_WIDTH-1:0]     flit_q;
    logic                      valid_q;

    logic [15:0]               nxt_idx;
    logic                      nxt_rd;
    logic [AXI_ADDR_WIDTH-1:0] nxt_addr;
    logic [VIRTUAL_CH_NUM-1:0] nxt_order;
    logic                      same_idx;
    logic                      last_pkt;
    logic [BODY_W-1:0]         body_first;
    logic [VIRTUAL_CH_NUM-1:0] pack_num;
    logic [AXI_ADDR_WIDTH-1:0] re_pack;
    logic [2*ID_WIDTH-1:0]     head_ids;
    logic [7:0]                head_len;
    logic [DATA_WIDTH-1:0]     head_flit;
    logic [DATA_WIDTH-1:0]     tail_flit;

    assign noc2axi_data = {valid_q, flit_q};

    // In mode 2 a write packet is followed by the read request of the same index.
    assign same_idx   = (mode_q == MODE_WR_RD) && !cur_rd;
    assign last_pkt   = !same_idx && (cur_idx == pkt_num_q - 16'd1);
    assign body_first = (int'(len_q) >= FLIT_NUM_MAX - 1) ? BODY_W'(FLIT_NUM_MAX - 1)
                                                          : BODY_W'(len_q);
    assign pack_num   = VIRTUAL_CH_NUM'(1) << ((pkt_num_q - 16'd1) % 16'(VIRTUAL_CH_NUM));
    assign re_pack    = {IDX_PAD_W'(cur_idx), len_q};
    assign head_ids   = (state == ST_IDLE) ? cfg_ids : ids_q;
    assign head_len   = (state == ST_IDLE) ? cfg_len : len_q;

    // Parameters of the next packet to be headed; in IDLE they come straight from cfg.
    always_comb begin
        nxt_idx   = '0;
        nxt_rd    = 1'b0;
        nxt_addr  = cfg_addr;
        nxt_order = VIRTUAL_CH_NUM'(1);
        if (state == ST_IDLE) begin
            nxt_rd = (cfg_mode == MODE_RD);
        end else if (same_idx) begin
            nxt_idx   = cur_idx;
            nxt_rd    = 1'b1;
            nxt_addr  = cur_addr;
            nxt_order = cur_order;
        end else begin
            nxt_idx   = cur_idx + 16'd1;
            nxt_rd    = (mode_q == MODE_RD);
            nxt_addr  = cur_addr + stride_q;
            nxt_order = {cur_order[VIRTUAL_CH_NUM-2:0], cur_order[VIRTUAL_CH_NUM-1]};
        end
    end

    noc_flit_pack #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ID_WIDTH      (ID_WIDTH),
        .VIRTUAL_CH_NUM(VIRTUAL_CH_NUM),
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)
    ) u_head_pack (
        .is_tail (1'b0),
        .src     (head_ids[2*ID_WIDTH-1:ID_WIDTH]),
        .dst     (head_ids[ID_WIDTH-1:0]),
        .ptype   (nxt_rd ? TYPE_RD_REQ : TYPE_WRITE),
        .vc_field(nxt_order),
        .axi_len (head_len),
        .word    (nxt_addr),
        .flit    (head_flit)
    );

    noc_flit_pack #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ID_WIDTH      (ID_WIDTH),
        .VIRTUAL_CH_NUM(VIRTUAL_CH_NUM),
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)
    ) u_tail_pack (
        .is_tail (1'b1),
        .src     (ids_q[2*ID_WIDTH-1:ID_WIDTH]),
        .dst     (ids_q[ID_WIDTH-1:0]),
        .ptype   (cur_rd ? TYPE_RD_REQ : TYPE_WRITE),
        .vc_field(pack_num),
        .axi_len (len_q),
        .word    (re_pack),
        .flit    (tail_flit)
    );

    // The registered outputs always describe the flit currently on the link;
    // backpressure freezes the whole machine.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_WR;
            pkt_num_q <= '0;
            len_q     <= '0;
            stride_q  <= '0;
            gap_q     <= '0;
            ids_q     <= '0;
            cur_idx   <= '0;
            cur_rd    <= 1'b0;
            cur_addr  <= '0;
            cur_order <= VIRTUAL_CH_NUM'(1);
            body_left <= '0;
            gap_cnt   <= '0;
            data_cnt  <= DATA_WIDTH'(1);
            flit_q    <= '0;
            valid_q   <= 1'b0;
            s_is_head <= 1'b0;
            s_is_tail <= 1'b0;
            gen_busy  <= 1'b0;
            gen_done  <= 1'b0;
        end else if (!nsu_busy) begin
            case (state)
                ST_IDLE: begin
                    gen_done <= 1'b0;
                    if (start) begin
                        mode_q    <= (cfg_mode == MODE_RSVD) ? MODE_WR : cfg_mode;
                        pkt_num_q <= cfg_pkt_num;
                        len_q     <= cfg_len;
                        stride_q  <= cfg_stride;
                        gap_q     <= cfg_gap;
                        ids_q     <= cfg_ids;
                        if (cfg_pkt_num == 16'd0) begin
                            state    <= ST_DONE;
                            gen_done <= 1'b1;
                        end else begin
                            state     <= ST_HEAD;
                            gen_busy  <= 1'b1;
                            flit_q    <= head_flit;
                            valid_q   <= 1'b1;
                            s_is_head <= 1'b1;
                            cur_idx   <= nxt_idx;
                            cur_rd    <= nxt_rd;
                            cur_addr  <= nxt_addr;
                            cur_order <= nxt_order;
                        end
                    end
                end
                ST_HEAD: begin
                    state     <= ST_BODY;
                    s_is_head <= 1'b0;
                    if (cur_rd) begin
                        flit_q    <= '1;
                        body_left <= '0;
                    end else begin
                        flit_q    <= data_cnt;
                        data_cnt  <= data_cnt + DATA_WIDTH'(1);
                        body_left <= body_first;
                    end
                end
                ST_BODY: begin
                    if (body_left != '0) begin
                        flit_q    <= data_cnt;
                        data_cnt  <= data_cnt + DATA_WIDTH'(1);
                        body_left <= body_left - BODY_W'(1);
                    end else begin
                        state     <= ST_TAIL;
                        flit_q    <= tail_flit;
                        s_is_tail <= 1'b1;
                    end
                end
                ST_TAIL: begin
                    s_is_tail <= 1'b0;
                    if (last_pkt) begin
                        state    <= ST_DONE;
                        flit_q   <= '0;
                        valid_q  <= 1'b0;
                        gen_busy <= 1'b0;
                        gen_done <= 1'b1;
                    end else if (gap_q != 8'd0) begin
                        state   <= ST_GAP;
                        gap_cnt <= gap_q;
                        flit_q  <= '0;
                        valid_q <= 1'b0;
                    end else begin
                        state     <= ST_HEAD;
                        flit_q    <= head_flit;
                        s_is_head <= 1'b1;
                        cur_idx   <= nxt_idx;
                        cur_rd    <= nxt_rd;
                        cur_addr  <= nxt_addr;
                        cur_order <= nxt_order;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 8'd1) begin
                        state     <= ST_HEAD;
                        flit_q    <= head_flit;
                        valid_q   <= 1'b1;
                        s_is_head <= 1'b1;
                        cur_idx   <= nxt_idx;
                        cur_rd    <= nxt_rd;
                        cur_addr  <= nxt_addr;
                        cur_order <= nxt_order;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    gen_done <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed self-checking bench for noc_traffic_gen: packet formats, modes,
// length clamp, backpressure hold, index wrap, start-while-busy and reset abort.
module tb_noc_traffic_gen;

    localparam int DW = 128;

    logic          noc_clk     = 1'b0;
    logic          noc_rst_n   = 1'b0;
    logic          start       = 1'b0;
    logic [1:0]    cfg_mode    = '0;
    logic [15:0]   cfg_pkt_num = '0;
    logic [7:0]    cfg_len     = '0;
    logic [31:0]   cfg_addr    = '0;
    logic [31:0]   cfg_stride  = '0;
    logic [7:0]    cfg_gap     = '0;
    logic [7:0]    cfg_ids     = '0;
    logic          nsu_busy    = 1'b0;
    logic [DW:0]   noc2axi_data;
    logic          s_is_head;
    logic          s_is_tail;
    logic          gen_busy;
    logic          gen_done;

    int            checks = 0;
    int            errors = 0;
    logic [3:0]    g_src  = 4'h3;
    logic [3:0]    g_dst  = 4'hC;
    logic [7:0]    g_len  = '0;
    logic [15:0]   g_pnum = '0;

    noc_traffic_gen dut (
        .noc_clk     (noc_clk),
        .noc_rst_n   (noc_rst_n),
        .start       (start),
        .cfg_mode    (cfg_mode),
        .cfg_pkt_num (cfg_pkt_num),
        .cfg_len     (cfg_len),
        .cfg_addr    (cfg_addr),
        .cfg_stride  (cfg_stride),
        .cfg_gap     (cfg_gap),
        .cfg_ids     (cfg_ids),
        .nsu_busy    (nsu_busy),
        .noc2axi_data(noc2axi_data),
        .s_is_head   (s_is_head),
        .s_is_tail   (s_is_tail),
        .gen_busy    (gen_busy),
        .gen_done    (gen_done)
    );

    always #5 noc_clk = ~noc_clk;

    function automatic logic [DW-1:0] mk_head(input logic [2:0] t, input logic [15:0] ord,
                                               input logic [31:0] addr);
        return {4'h5, g_src, g_dst, t, ord, g_len, addr, 4'hA, 53'd0};
    endfunction

    function automatic logic [DW-1:0] mk_tail(input logic [2:0] t, input logic [15:0] idx);
        return {4'h0, g_src, g_dst, t, g_pnum, g_len, 8'h00, idx, g_len, 4'hF, 53'd0};
    endfunction

    task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge noc_clk);
        #1;
    endtask

    task automatic go(input logic [1:0] mode, input logic [15:0] pkt, input logic [7:0] len,
                      input logic [31:0] addr, input logic [31:0] stride, input logic [7:0] gap,
                      input logic [15:0] pnum);
        cfg_mode    = mode;
        cfg_pkt_num = pkt;
        cfg_len     = len;
        cfg_addr    = addr;
        cfg_stride  = stride;
        cfg_gap     = gap;
        cfg_ids     = {g_src, g_dst};
        g_len       = len;
        g_pnum      = pnum;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    task automatic exp_flit(input string tag, input logic [DW-1:0] flit, input logic is_hd,
                            input logic is_tl);
        chk(tag, noc2axi_data, {1'b1, flit});
        chk({tag, "_head"}, s_is_head, is_hd);
        chk({tag, "_tail"}, s_is_tail, is_tl);
        chk({tag, "_busy"}, gen_busy, 1'b1);
        step();
    endtask

    task automatic exp_pkt(input logic rd, input logic [15:0] idx, input logic [15:0] ord,
                           input logic [31:0] addr, input int nb, input logic [DW-1:0] d0);
        logic [2:0] t;
        t = rd ? 3'b010 : 3'b100;
        exp_flit($sformatf("head%0d", idx), mk_head(t, ord, addr), 1'b1, 1'b0);
        for (int b = 0; b < nb; b++)
            exp_flit($sformatf("body%0d_%0d", idx, b), rd ? {DW{1'b1}} : d0 + DW'(b), 1'b0, 1'b0);
        exp_flit($sformatf("tail%0d", idx), mk_tail(t, idx), 1'b0, 1'b1);
    endtask

    task automatic exp_gap(input logic pulse_start);
        for (int g = 0; g < 2; g++) begin
            start = pulse_start && (g == 0);
            chk("gap_data", noc2axi_data, '0);
            chk("gap_head", s_is_head, 1'b0);
            chk("gap_done", gen_done, 1'b0);
            chk("gap_busy", gen_busy, 1'b1);
            step();
        end
        start = 1'b0;
    endtask

    task automatic exp_done();
        chk("done_pulse", gen_done, 1'b1);
        chk("done_busy", gen_busy, 1'b0);
        chk("done_data", noc2axi_data, '0);
        step();
        chk("done_clear", gen_done, 1'b0);
    endtask

    initial begin
        #3;
        chk("rst_data", noc2axi_data, '0);
        chk("rst_head", s_is_head, 1'b0);
        chk("rst_tail", s_is_tail, 1'b0);
        chk("rst_busy", gen_busy, 1'b0);
        chk("rst_done", gen_done, 1'b0);
        @(negedge noc_clk);
        noc_rst_n = 1'b1;
        step();

        // Mode 0, four back-to-back packets, 4 body flits each.
        go(2'd0, 16'd4, 8'h03, 32'h2000, 32'h40, 8'd0, 16'h0008);
        exp_pkt(1'b0, 16'd0, 16'h0001, 32'h2000, 4, 128'd1);
        exp_pkt(1'b0, 16'd1, 16'h0002, 32'h2040, 4, 128'd5);
        exp_pkt(1'b0, 16'd2, 16'h0004, 32'h2080, 4, 128'd9);
        exp_pkt(1'b0, 16'd3, 16'h0008, 32'h20C0, 4, 128'd13);
        exp_done();

        // Length clamp to 16 body flits.
        go(2'd0, 16'd1, 8'h29, 32'h100, 32'h0, 8'd0, 16'h0001);
        exp_pkt(1'b0, 16'd0, 16'h0001, 32'h100, 16, 128'd17);
        exp_done();

        // Read request: one all-ones body, data counter untouched.
        go(2'd1, 16'd1, 8'h29, 32'h300, 32'h0, 8'd0, 16'h0001);
        exp_pkt(1'b1, 16'd0, 16'h0001, 32'h300, 1, '0);
        exp_done();

        // Backpressure for 5 cycles mid-body.
        go(2'd0, 16'd1, 8'h03, 32'h400, 32'h0, 8'd0, 16'h0001);
        exp_flit("bp_head", mk_head(3'b100, 16'h0001, 32'h400), 1'b1, 1'b0);
        exp_flit("bp_b0", 128'd33, 1'b0, 1'b0);
        exp_flit("bp_b1", 128'd34, 1'b0, 1'b0);
        nsu_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold", noc2axi_data, {1'b1, 128'd35});
            chk("bp_hold_busy", gen_busy, 1'b1);
        end
        nsu_busy = 1'b0;
        exp_flit("bp_b2", 128'd35, 1'b0, 1'b0);
        exp_flit("bp_b3", 128'd36, 1'b0, 1'b0);
        exp_flit("bp_tail", mk_tail(3'b100, 16'd0), 1'b0, 1'b1);
        exp_done();

        // 17 packets with gap 2: order wraps at index 16; start while busy ignored.
        go(2'd0, 16'd17, 8'h00, 32'h0, 32'h4, 8'd2, 16'h0001);
        for (int i = 0; i < 17; i++) begin
            exp_pkt(1'b0, 16'(i), 16'h0001 << (i % 16), 32'(4 * i), 1, 128'(37 + i));
            if (i == 4) begin
                cfg_mode    = 2'd1;
                cfg_pkt_num = 16'd1;
                cfg_addr    = 32'hFFFF0000;
            end
            if (i < 16) exp_gap(i == 4);
        end
        exp_done();

        // Reset mid-body aborts the packet; next start begins at index 0.
        go(2'd0, 16'd2, 8'h03, 32'h500, 32'h10, 8'd0, 16'h0002);
        exp_flit("ra_head", mk_head(3'b100, 16'h0001, 32'h500), 1'b1, 1'b0);
        exp_flit("ra_b0", 128'd54, 1'b0, 1'b0);
        noc_rst_n = 1'b0;
        #1;
        chk("ra_data", noc2axi_data, '0);
        chk("ra_head0", s_is_head, 1'b0);
        chk("ra_tail0", s_is_tail, 1'b0);
        chk("ra_busy", gen_busy, 1'b0);
        chk("ra_done", gen_done, 1'b0);
        step();
        noc_rst_n = 1'b1;
        step();
        chk("ra_no_tail", noc2axi_data, '0);
        chk("ra_no_tail_flag", s_is_tail, 1'b0);
        go(2'd0, 16'd1, 8'h00, 32'h600, 32'h0, 8'd0, 16'h0001);
        exp_pkt(1'b0, 16'd0, 16'h0001, 32'h600, 1, 128'd1);
        exp_done();

        // Zero packets: straight to done.
        go(2'd0, 16'd0, 8'h00, 32'h0, 32'h0, 8'd0, 16'h0000);
        exp_done();

        // Mode 2: write then read request of the same index.
        go(2'd2, 16'd1, 8'h00, 32'h700, 32'h10, 8'd0, 16'h0001);
        exp_pkt(1'b0, 16'd0, 16'h0001, 32'h700, 1, 128'd2);
        exp_pkt(1'b1, 16'd0, 16'h0001, 32'h700, 1, '0);
        exp_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
